// File: rtl/irq_coalescing_controller_pkg.sv
// Shared types and default sizing for the interrupt coalescing controller.
package irq_ctrl_pkg;

  localparam int unsigned IRQ_NUM_SRC_DEF = 8;
  localparam int unsigned IRQ_CNT_W_DEF   = 8;
  localparam int unsigned IRQ_TMO_W_DEF   = 16;

  // Encoding is visible to software through the status CSR, keep it fixed.
  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_COLLECT = 2'd1,
    IRQ_ASSERT  = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_coalescing_controller_if.sv
// CSR-side bundle of the interrupt coalescing controller: configuration
// from the HPS (master) and status back from the controller (slave).
interface irq_coalescing_controller_if
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = IRQ_NUM_SRC_DEF,
  parameter int CNT_W   = IRQ_CNT_W_DEF,
  parameter int TMO_W   = IRQ_TMO_W_DEF
) ();

  logic [NUM_SRC-1:0] src_edge_mode;
  logic [NUM_SRC-1:0] irq_enable;
  logic               clr_valid;
  logic [NUM_SRC-1:0] clr_mask;
  logic [CNT_W-1:0]   coalesce_thresh;
  logic [TMO_W-1:0]   coalesce_timeout;
  logic [NUM_SRC-1:0] pending;
  irq_state_e         irq_state;
  logic [CNT_W-1:0]   event_count;

  modport master (
    output src_edge_mode, irq_enable, clr_valid, clr_mask,
           coalesce_thresh, coalesce_timeout,
    input  pending, irq_state, event_count
  );

  modport slave (
    input  src_edge_mode, irq_enable, clr_valid, clr_mask,
           coalesce_thresh, coalesce_timeout,
    output pending, irq_state, event_count
  );

endinterface

// File: rtl/irq_coalescing_controller_src_cell.sv
// One interrupt source: edge/level capture into a sticky pending bit with
// write-1-to-clear. A set in the same cycle as a clear keeps the bit set.
module irq_src_cell (
  input  logic clk,
  input  logic reset,
  input  logic src_i,
  input  logic edge_mode_i,
  input  logic clr_i,
  output logic pending_o
);

  logic src_prev_q;
  logic pending_q;
  logic pending_d;
  logic set_evt;

  // Decide whether this cycle sets the pending bit and apply the clear.
  always_comb begin
    set_evt   = 1'b0;
    pending_d = pending_q;
    if (edge_mode_i) begin
      set_evt = src_i & ~src_prev_q;
    end else begin
      set_evt = src_i;
    end
    pending_d = set_evt | (pending_q & ~clr_i);
  end

  // Source history for edge detection and the pending latch itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_prev_q <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      src_prev_q <= src_i;
      pending_q  <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/irq_coalescing_controller.sv
// Aggregates NUM_SRC interrupt sources onto one HPS IRQ line, coalescing
// new enabled events by count threshold or by a timeout.
module irq_coalescing_controller
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = IRQ_NUM_SRC_DEF,
  parameter int CNT_W   = IRQ_CNT_W_DEF,
  parameter int TMO_W   = IRQ_TMO_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SRC-1:0]          src_event_i,
  irq_coalescing_controller_if.slave  csr,
  output logic                        irq_to_hps_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_SRC-1:0] pending_s;
  logic [NUM_SRC-1:0] clr_s;
  logic [NUM_SRC-1:0] act;
  logic [NUM_SRC-1:0] act_q;
  logic               new_evt;
  logic [CNT_W-1:0]   thr_eff;
  logic [CNT_W-1:0]   cnt_inc;
  logic               tmo_hit;

  irq_state_e         state_q;
  logic               irq_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [TMO_W-1:0]   timer_q;

  assign clr_s = csr.clr_mask & {NUM_SRC{csr.clr_valid}};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_src_cell u_cell (
      .clk         (clk),
      .reset       (reset),
      .src_i       (src_event_i[g]),
      .edge_mode_i (csr.src_edge_mode[g]),
      .clr_i       (clr_s[g]),
      .pending_o   (pending_s[g])
    );
  end

  // Active sources, event detection, effective threshold and timeout hit.
  always_comb begin
    act     = pending_s & csr.irq_enable;
    new_evt = |(act & ~act_q);
    if (csr.coalesce_thresh == {CNT_W{1'b0}}) begin
      thr_eff = CNT_ONE;
    end else begin
      thr_eff = csr.coalesce_thresh;
    end
    if (new_evt && (cnt_q != CNT_MAX)) begin
      cnt_inc = cnt_q + CNT_ONE;
    end else begin
      cnt_inc = cnt_q;
    end
    tmo_hit = (csr.coalesce_timeout != {TMO_W{1'b0}}) &&
              (timer_q == (csr.coalesce_timeout - TMO_W'(1)));
  end

  // Previous-cycle active set, so a rising bit is seen as a new event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_q <= {NUM_SRC{1'b0}};
    end else begin
      act_q <= act;
    end
  end

  // Coalescing FSM with its event counter, timer and registered IRQ output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IRQ_IDLE;
      irq_q   <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      timer_q <= {TMO_W{1'b0}};
    end else begin
      case (state_q)
        IRQ_IDLE: begin
          if (new_evt) begin
            cnt_q   <= cnt_inc;
            timer_q <= {TMO_W{1'b0}};
            if (thr_eff == CNT_ONE) begin
              state_q <= IRQ_ASSERT;
              irq_q   <= 1'b1;
            end else begin
              state_q <= IRQ_COLLECT;
              irq_q   <= 1'b0;
            end
          end else begin
            cnt_q <= {CNT_W{1'b0}};
            irq_q <= 1'b0;
          end
        end
        IRQ_COLLECT: begin
          timer_q <= timer_q + TMO_W'(1);
          if (act == {NUM_SRC{1'b0}}) begin
            state_q <= IRQ_IDLE;
            irq_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
          end else if ((cnt_inc >= thr_eff) || tmo_hit) begin
            state_q <= IRQ_ASSERT;
            irq_q   <= 1'b1;
            cnt_q   <= cnt_inc;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        IRQ_ASSERT: begin
          if (act == {NUM_SRC{1'b0}}) begin
            state_q <= IRQ_IDLE;
            irq_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= IRQ_IDLE;
          irq_q   <= 1'b0;
          cnt_q   <= {CNT_W{1'b0}};
          timer_q <= {TMO_W{1'b0}};
        end
      endcase
    end
  end

  assign irq_to_hps_o    = irq_q;
  assign csr.pending     = pending_s;
  assign csr.irq_state   = state_q;
  assign csr.event_count = cnt_q;

endmodule

// File: tb/tb_irq_coalescing_controller.sv
// Bench for irq_coalescing_controller: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model.
module tb_irq_coalescing_controller;
  import irq_ctrl_pkg::*;

  localparam int NS = 8;
  localparam int CW = 8;
  localparam int TW = 16;
  localparam int S_IDLE    = 0;
  localparam int S_COLLECT = 1;
  localparam int S_ASSERT  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NS-1:0] src_event = 8'h00;
  logic          irq;

  irq_coalescing_controller_if #(.NUM_SRC(NS), .CNT_W(CW), .TMO_W(TW)) csr_if ();

  irq_coalescing_controller #(.NUM_SRC(NS), .CNT_W(CW), .TMO_W(TW)) dut (
    .clk          (clk),
    .reset        (reset),
    .src_event_i  (src_event),
    .csr          (csr_if.slave),
    .irq_to_hps_o (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: pending bits, last source sample, last enabled-pending set,
  // coalescing phase, events seen this episode and cycles spent collecting.
  bit [7:0] m_pend, m_prev, m_act_prev;
  int       m_state, m_cnt, m_timer;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 8'h00; m_prev = 8'h00; m_act_prev = 8'h00;
    m_state = S_IDLE; m_cnt = 0; m_timer = 0;
  endtask

  task automatic model_edge();
    bit [7:0] act, setb, clr;
    bit       evt;
    int       thr, tmo, nxt;
    if (reset) begin
      model_reset();
    end else begin
      act = m_pend & csr_if.irq_enable;
      evt = |(act & ~m_act_prev);
      m_act_prev = act;
      thr = (csr_if.coalesce_thresh == 8'd0) ? 1 : int'(csr_if.coalesce_thresh);
      tmo = int'(csr_if.coalesce_timeout);
      nxt = (m_cnt + int'(evt) > 255) ? 255 : m_cnt + int'(evt);
      case (m_state)
        S_IDLE: if (evt) begin
          m_cnt = 1; m_timer = 0;
          m_state = (thr == 1) ? S_ASSERT : S_COLLECT;
        end
        S_COLLECT: begin
          if (act == 8'h00) begin
            m_state = S_IDLE; m_cnt = 0;
          end else if (nxt >= thr || (tmo != 0 && m_timer == tmo - 1)) begin
            m_state = S_ASSERT; m_cnt = nxt;
          end else begin
            m_cnt = nxt; m_timer = (m_timer + 1) % 65536;
          end
        end
        S_ASSERT: begin
          if (act == 8'h00) begin
            m_state = S_IDLE; m_cnt = 0;
          end else begin
            m_cnt = nxt;
          end
        end
        default: m_state = S_IDLE;
      endcase
      setb = (csr_if.src_edge_mode & src_event & ~m_prev) | (~csr_if.src_edge_mode & src_event);
      clr  = csr_if.clr_valid ? csr_if.clr_mask : 8'h00;
      m_pend = setb | (m_pend & ~clr);
      m_prev = src_event;
    end
  endtask

  task automatic compare_all();
    check("pending", 32'(csr_if.pending), 32'(m_pend));
    check("irq", 32'(irq), 32'(m_state == S_ASSERT));
    check("state", 32'(csr_if.irq_state), 32'(m_state));
    check("count", 32'(csr_if.event_count), 32'(m_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic cfg(input logic [7:0] edge_m, input logic [7:0] en,
                     input logic [7:0] thr, input logic [15:0] tmo);
    csr_if.src_edge_mode    = edge_m;
    csr_if.irq_enable       = en;
    csr_if.coalesce_thresh  = thr;
    csr_if.coalesce_timeout = tmo;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src_event = 8'h00;
    csr_if.clr_valid = 1'b0;
    csr_if.clr_mask = 8'h00;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    csr_if.clr_valid = 1'b0;
    csr_if.clr_mask  = 8'h00;
    cfg(8'hFF, 8'hFF, 8'd1, 16'd0);
    model_reset();
    #1;
    check("rst_pending", 32'(csr_if.pending), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_state", 32'(csr_if.irq_state), 32'h0);
    check("rst_count", 32'(csr_if.event_count), 32'h0);
    step();
    reset = 1'b0;

    // 1: single edge pulse, threshold 1, then W1C
    src_event = 8'h01; step();
    check("t1_pend", 32'(csr_if.pending), 32'h01);
    check("t1_irq_early", 32'(irq), 32'h0);
    src_event = 8'h00; step();
    check("t1_irq", 32'(irq), 32'h1);
    csr_if.clr_valid = 1'b1; csr_if.clr_mask = 8'h01; step();
    check("t1_clr", 32'(csr_if.pending), 32'h0);
    csr_if.clr_valid = 1'b0; step();
    check("t1_irq_low", 32'(irq), 32'h0);
    check("t1_idle", 32'(csr_if.irq_state), 32'(S_IDLE));

    // 2: threshold 3 on three separate sources
    do_reset();
    cfg(8'hFF, 8'hFF, 8'd3, 16'd0);
    src_event = 8'h02; step();
    src_event = 8'h04; step();
    src_event = 8'h08; step();
    check("t2_irq_before", 32'(irq), 32'h0);
    src_event = 8'h00; step();
    check("t2_irq", 32'(irq), 32'h1);
    check("t2_count", 32'(csr_if.event_count), 32'd3);

    // 3: timeout 10 with a single event below threshold
    do_reset();
    cfg(8'hFF, 8'hFF, 8'd4, 16'd10);
    src_event = 8'h01; step();
    src_event = 8'h00; step();
    check("t3_collect", 32'(csr_if.irq_state), 32'(S_COLLECT));
    for (int i = 0; i < 9; i++) begin
      step();
      check("t3_wait", 32'(irq), 32'h0);
    end
    step();
    check("t3_timeout", 32'(irq), 32'h1);

    // 4: level source held high resists clear
    do_reset();
    cfg(8'hDF, 8'hFF, 8'd1, 16'd0);
    src_event = 8'h20; step(); step();
    check("t4_irq", 32'(irq), 32'h1);
    csr_if.clr_valid = 1'b1; csr_if.clr_mask = 8'h20; step();
    check("t4_pend_held", 32'(csr_if.pending[5]), 32'h1);
    csr_if.clr_valid = 1'b0; step();
    check("t4_irq_held", 32'(irq), 32'h1);
    src_event = 8'h00; csr_if.clr_valid = 1'b1; step();
    check("t4_pend_clr", 32'(csr_if.pending), 32'h0);
    csr_if.clr_valid = 1'b0; step();
    check("t4_idle", 32'(csr_if.irq_state), 32'(S_IDLE));

    // 5: disabled source latches, enabling it raises the IRQ
    do_reset();
    cfg(8'hFF, 8'hBF, 8'd1, 16'd0);
    src_event = 8'h40; step();
    src_event = 8'h00; step(); step();
    check("t5_pend", 32'(csr_if.pending), 32'h40);
    check("t5_irq_off", 32'(irq), 32'h0);
    csr_if.irq_enable = 8'hFF; step();
    check("t5_irq_on", 32'(irq), 32'h1);

    // 6: set beats clear, then asynchronous reset while asserted
    do_reset();
    cfg(8'hFF, 8'hFF, 8'd1, 16'd0);
    src_event = 8'h04; csr_if.clr_valid = 1'b1; csr_if.clr_mask = 8'h04; step();
    check("t6_set_wins", 32'(csr_if.pending), 32'h04);
    src_event = 8'h00; csr_if.clr_valid = 1'b0; step();
    check("t6_irq", 32'(irq), 32'h1);
    reset = 1'b1;
    #1;
    model_reset();
    check("t6_rst_pend", 32'(csr_if.pending), 32'h0);
    check("t6_rst_irq", 32'(irq), 32'h0);
    check("t6_rst_state", 32'(csr_if.irq_state), 32'h0);
    check("t6_rst_count", 32'(csr_if.event_count), 32'h0);
    step();
    reset = 1'b0;

    // Random traffic against the model
    cfg(8'($urandom), 8'hFF, 8'd2, 16'd6);
    for (int c = 0; c < 3000; c++) begin
      src_event = 8'($urandom & $urandom & $urandom);
      csr_if.clr_valid = ($urandom_range(5) == 0);
      csr_if.clr_mask  = 8'($urandom);
      if ($urandom_range(49) == 0) csr_if.irq_enable = 8'($urandom | $urandom);
      if ($urandom_range(99) == 0) csr_if.src_edge_mode = 8'($urandom);
      if ($urandom_range(99) == 0) csr_if.coalesce_thresh = 8'($urandom_range(5));
      if ($urandom_range(99) == 0) csr_if.coalesce_timeout = 16'($urandom_range(15));
      reset = ($urandom_range(499) == 0);
      step();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
